mpadd_seq: RTL and testbench
============================

Name: mpadd_seq

Overview:
Multi-precision add/subtract sequencer. It reuses one W-bit ripple-carry adder slice over WORDS consecutive cycles to produce a W*WORDS-bit sum, carry-out and signed overflow. The carry is chained through a register between word steps. It sits between a requester using a start/done handshake and the narrow adder datapath, so wide arithmetic costs no extra adder area.

Parameters:
W, 16, width of the adder slice in bits
WORDS, 4, number of W-bit words per operand; total operand width N = W*WORDS, WORDS >= 2

Ports:
clk  input  1  system clock, all state updates on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
sub  input  1  0 = add, 1 = subtract; sampled with start
cin  input  1  carry-in for add; ignored when sub=1
a  input  N  operand A; sampled with start
b  input  N  operand B; sampled with start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse when results become valid
sum  output  N  result register
cout  output  1  final carry-out of the top word
overflow  output  1  two's-complement overflow of the N-bit result

Behaviour:
- Reset (rst=1 at clk edge):
  - FSM goes to IDLE.
  - busy=0, done=0, sum=0, cout=0, overflow=0.
  - Word index and carry register clear to 0.
  - Reset has priority over every other event, including mid-RUN; partial results are discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1: latch a into opA.
  - Latch b into opB when sub=0, or ~b when sub=1.
  - Carry register <= cin when sub=0, 1 when sub=1.
  - Word index k <= 0; go to RUN.
  - If start=0: stay in IDLE; outputs hold their last values.
- RUN, one word per cycle, least-significant word first:
  - {c, s} = opA[k] + opB[k] + carry, W-bit add.
  - sum[k*W +: W] <= s; carry <= c.
  - When k = WORDS-1:
    - cout <= c.
    - overflow <= (carry into bit W-1 of the top word) XOR c.
    - Go to DONE.
  - Otherwise k <= k+1.
- DONE: done=1 for exactly this cycle; go to IDLE next cycle.
- Latency:
  - start sampled at edge T → RUN occupies edges T+1 .. T+WORDS.
  - done is high in the cycle after edge T+WORDS.
  - One operation therefore takes WORDS+2 cycles from start edge to the next accept.
- start while busy=1 is ignored (not queued). a, b, sub and cin may change freely after the start edge.
- sum is written word by word during RUN, so intermediate values are visible. It is valid only from the done cycle and holds until the next accepted start.
- cout and overflow update only at the last word; they hold stale values during RUN.
- Subtract semantics: result = a - b mod 2^N. cout=1 means no borrow (a >= b unsigned).
- Word index wraps only via FSM exit; no index overflow beyond WORDS-1.

Optional Feature:
MPADD_ZERO_FLAG_EN:
- Defined:
  - Adds output port zero (1 bit).
  - An internal accumulator is cleared at accept and ORs each word's s during RUN.
  - zero <= ~(accumulated OR) at the last word, updated together with cout.
  - zero resets to 0 and holds until the next completion.
- Undefined: no zero port and no accumulator logic.

Test Plan:
- Carry chain across words: add, a=64'h0000_0000_0000_FFFF, b=64'h1, cin=0 → done after WORDS+1 cycles, sum=64'h0000_0000_0001_0000, cout=0, overflow=0.
- Full ripple with carry-in: add, a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1 → sum=0, cout=1, overflow=0; zero=1 if MPADD_ZERO_FLAG_EN.
- Signed overflow: add, a=64'h7FFF_FFFF_FFFF_FFFF, b=64'h1, cin=0 → sum=64'h8000_0000_0000_0000, cout=0, overflow=1. Also a=b=64'h8000_0000_0000_0000 → sum=0, cout=1, overflow=1.
- Subtract: sub=1, a=9, b=5 → sum=4, cout=1. Then sub=1, a=5, b=9 → sum=64'hFFFF_FFFF_FFFF_FFFC, cout=0, overflow=0.
- Busy and reset behaviour: pulse start again during RUN with different operands → ignored, first result unchanged. Then start a new op and assert rst at the second RUN cycle → next cycle IDLE, busy=0, sum=0, no done pulse.
- Back-to-back requests: hold start=1 continuously with a=17, b=56 → a done pulse every WORDS+2 cycles, sum=73 each time.

Source files
------------

// File: rtl/mpadd_seq.sv
// Multi-precision add/subtract sequencer: one W-bit adder slice reused over WORDS cycles.
// Optional zero-result flag port enabled by defining MPADD_ZERO_FLAG_EN.
module mpadd_seq #(
    parameter int W     = 16,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sub,
    input  logic               cin,
    input  logic [W*WORDS-1:0] a,
    input  logic [W*WORDS-1:0] b,
    output logic               busy,
    output logic               done,
    output logic [W*WORDS-1:0] sum,
    output logic               cout,
    output logic               overflow
`ifdef MPADD_ZERO_FLAG_EN
    ,
    output logic               zero
`endif
);

    localparam int N  = W * WORDS;
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    // Handshake: start is accepted only while idle (busy=0); operands are captured on that
    // edge, busy stays high until the DONE cycle ends, done pulses once with results valid.
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    state_t         state_next;
    logic [KW-1:0]  k;
    logic           carry;
    logic [N-1:0]   op_a;
    logic [N-1:0]   op_b;
    logic [W-1:0]   slice_a;
    logic [W-1:0]   slice_b;
    logic [W-1:0]   slice_s;
    logic           slice_c;
    logic           msb_c;
    logic           last;
`ifdef MPADD_ZERO_FLAG_EN
    logic [W-1:0]   acc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign last = (k == K_LAST);

    // The single adder slice; msb_c recovers the carry into the top bit for overflow.
    always_comb begin
        slice_a            = op_a[k*W +: W];
        slice_b            = op_b[k*W +: W];
        {slice_c, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {{W{1'b0}}, carry};
        msb_c              = slice_a[W-1] ^ slice_b[W-1] ^ slice_s[W-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k        <= '0;
            carry    <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
`ifdef MPADD_ZERO_FLAG_EN
            acc      <= '0;
            zero     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        k     <= '0;
`ifdef MPADD_ZERO_FLAG_EN
                        acc   <= '0;
`endif
                    end
                end
                RUN: begin
                    sum[k*W +: W] <= slice_s;
                    carry         <= slice_c;
`ifdef MPADD_ZERO_FLAG_EN
                    acc           <= acc | slice_s;
`endif
                    if (last) begin
                        cout     <= slice_c;
                        overflow <= msb_c ^ slice_c;
`ifdef MPADD_ZERO_FLAG_EN
                        zero     <= ~|(acc | slice_s);
`endif
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mpadd_seq.sv
// Directed bench for mpadd_seq: reference model feeds an expected queue, a done monitor pops it.
module tb_mpadd_seq;
    localparam int W     = 16;
    localparam int WORDS = 4;
    localparam int N     = W * WORDS;
    localparam int EW    = N + 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic         cin;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         zero_obs;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int cyc = 0;
    int done_cyc[$];
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_e;

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

`ifdef MPADD_ZERO_FLAG_EN
    logic zero;
    assign zero_obs = zero;
`else
    assign zero_obs = 1'b0;
`endif

    mpadd_seq #(.W(W), .WORDS(WORDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .cin      (cin),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
`ifdef MPADD_ZERO_FLAG_EN
        ,
        .zero     (zero)
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: whole N-bit add, overflow from operand/result sign rule.
    function automatic logic [EW-1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                            input logic s, input logic c);
        logic [N-1:0] yy;
        logic [N:0]   full;
        logic         v;
        logic         z;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {{N{1'b0}}, (s ? 1'b1 : c)};
        v    = (x[N-1] == yy[N-1]) && (full[N-1] != x[N-1]);
`ifdef MPADD_ZERO_FLAG_EN
        z    = (full[N-1:0] == '0);
`else
        z    = 1'b0;
`endif
        return {z, v, full[N], full[N-1:0]};
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 128'(1), 128'(0));
            end else begin
                exp_e = exp_q.pop_front();
                check("result", 128'({zero_obs, overflow, cout, sum}), 128'(exp_e));
            end
        end
    end

    // Leaves the bench 1ns after the accepting edge, with operands scrambled.
    task automatic drive_start(input logic [N-1:0] x, input logic [N-1:0] y,
                               input logic s, input logic c);
        @(posedge clk);
        #1;
        a = x; b = y; sub = s; cin = c; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = {$urandom, $urandom};
        b     = {$urandom, $urandom};
        sub   = 1'($urandom_range(0, 1));
        cin   = 1'($urandom_range(0, 1));
    endtask

    task automatic do_op(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic s, input logic c);
        int   n;
        int   base;
        logic busy_ok;
        n       = 0;
        busy_ok = 1'b1;
        exp_q.push_back(model(x, y, s, c));
        base = done_cnt;
        drive_start(x, y, s, c);
        while (done_cnt == base && n < 20) begin
            @(negedge clk);
            #1;
            n++;
            busy_ok = busy_ok & busy;
        end
        check({tag, "_latency"}, 128'(n), 128'(WORDS + 1));
        check({tag, "_busy"}, 128'(busy_ok), 128'(1));
    endtask

    initial begin
        int base;
        int nd;
        int n;
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", 128'({busy, done, zero_obs, overflow, cout, sum}), 128'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        do_op("carry_chain", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
        do_op("ripple_cin",  64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1);
        do_op("ovf_pos",     64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        do_op("ovf_neg",     64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        do_op("sub_9_5",     64'd9, 64'd5, 1'b1, 1'b0);
        do_op("sub_5_9",     64'd5, 64'd9, 1'b1, 1'b1);

        // start pulsed during RUN must be ignored
        exp_q.push_back(model(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0));
        base = done_cnt;
        drive_start(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        a = 64'hDEAD_BEEF_0000_0001; b = 64'h0000_0000_0000_0FFF; sub = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        check("busy_ignore_dones", 128'(done_cnt - base), 128'(1));

        // reset in the second RUN cycle discards the op
        base = done_cnt;
        drive_start(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_midrun", 128'({busy, done, cout, overflow, sum}), 128'(0));
        repeat (10) @(posedge clk);
        check("reset_no_done", 128'(done_cnt - base), 128'(0));

        // back-to-back with start held high
        repeat (3) exp_q.push_back(model(64'd17, 64'd56, 1'b0, 1'b0));
        base = done_cnt;
        nd   = done_cyc.size();
        n    = 0;
        @(posedge clk);
        #1;
        a = 64'd17; b = 64'd56; sub = 1'b0; cin = 1'b0; start = 1'b1;
        while (done_cnt < base + 3 && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1 start = 1'b0;
        check("b2b_dones", 128'(done_cnt - base), 128'(3));
        if (done_cyc.size() >= nd + 3) begin
            check("b2b_period_1", 128'(done_cyc[nd+1] - done_cyc[nd]), 128'(WORDS + 2));
            check("b2b_period_2", 128'(done_cyc[nd+2] - done_cyc[nd+1]), 128'(WORDS + 2));
        end

        repeat (12) @(posedge clk);
        check("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
